// File: rtl/mc_hazard_scoreboard.sv
// Hazard unit for the 5-stage pipeline: E/D forwarding, load-use and branch stalls,
// plus a scoreboard of fixed-latency multi-cycle ops (mul/div) with MC_SLOTS entries.

module mc_hazard_slot #(
  parameter int AW     = 5,
  parameter int MC_LAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] dst_in,
  output logic          valid,
  output logic [AW-1:0] dst,
  output logic [3:0]    cnt,
  output logic          done
);
  assign done = valid && (cnt == 4'd0);

  // A completing slot stays valid through its write-back cycle, so it cannot be reloaded then.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      dst   <= '0;
      cnt   <= 4'd0;
    end else if (load) begin
      valid <= 1'b1;
      dst   <= dst_in;
      cnt   <= 4'(MC_LAT - 1);
    end else if (valid) begin
      if (cnt == 4'd0) valid <= 1'b0;
      else             cnt   <= cnt - 4'd1;
    end
  end
endmodule

module mc_hazard_scoreboard #(
  parameter int AW       = 5,
  parameter int MC_LAT   = 4,
  parameter int MC_SLOTS = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rs_d,
  input  logic [AW-1:0] rt_d,
  input  logic          use_rs_d,
  input  logic          use_rt_d,
  input  logic [AW-1:0] dst_d,
  input  logic          wr_d,
  input  logic          mc_d,
  input  logic          branch_d,
  input  logic [AW-1:0] rs_e,
  input  logic [AW-1:0] rt_e,
  input  logic [AW-1:0] writereg_e,
  input  logic          regwrite_e,
  input  logic          memtoreg_e,
  input  logic [AW-1:0] writereg_m,
  input  logic          regwrite_m,
  input  logic          memtoreg_m,
  input  logic [AW-1:0] writereg_w,
  input  logic          regwrite_w,
  output logic [1:0]    forward_ae,
  output logic [1:0]    forward_be,
  output logic          forward_ad,
  output logic          forward_bd,
  output logic          stall_f,
  output logic          stall_d,
  output logic          flush_e,
  output logic          mc_wb_en,
  output logic [AW-1:0] mc_wb_reg,
  output logic          mc_busy
);
  // r0 is hardwired zero, so it never produces a dependency
  function automatic logic hit(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  logic [MC_SLOTS-1:0]         slot_vld, slot_done, slot_raw, slot_waw, sel, load;
  logic [MC_SLOTS-1:0][AW-1:0] slot_dst;
  logic [MC_SLOTS-1:0][3:0]    slot_cnt;
  logic any_free, lw_stall, br_stall, raw_stall, waw_stall, full_stall, stall, issue;

  always_comb begin
    forward_ae = 2'b00;
    if (regwrite_m && hit(rs_e, writereg_m))      forward_ae = 2'b10;
    else if (regwrite_w && hit(rs_e, writereg_w)) forward_ae = 2'b01;
    forward_be = 2'b00;
    if (regwrite_m && hit(rt_e, writereg_m))      forward_be = 2'b10;
    else if (regwrite_w && hit(rt_e, writereg_w)) forward_be = 2'b01;
  end

  assign forward_ad = regwrite_m && hit(rs_d, writereg_m);
  assign forward_bd = regwrite_m && hit(rt_d, writereg_m);

  assign lw_stall = memtoreg_e &&
                    ((use_rs_d && hit(rs_d, writereg_e)) || (use_rt_d && hit(rt_d, writereg_e)));
  assign br_stall = branch_d &&
                    ((regwrite_e && (hit(rs_d, writereg_e) || hit(rt_d, writereg_e))) ||
                     (memtoreg_m && (hit(rs_d, writereg_m) || hit(rt_d, writereg_m))));

  genvar g;
  generate
    for (g = 0; g < MC_SLOTS; g++) begin : g_slot
      mc_hazard_slot #(.AW(AW), .MC_LAT(MC_LAT)) u_slot (
        .clk    (clk),
        .rst    (rst),
        .load   (load[g]),
        .dst_in (dst_d),
        .valid  (slot_vld[g]),
        .dst    (slot_dst[g]),
        .cnt    (slot_cnt[g]),
        .done   (slot_done[g])
      );
      assign slot_raw[g] = slot_vld[g] &&
                           ((use_rs_d && hit(rs_d, slot_dst[g])) || (use_rt_d && hit(rt_d, slot_dst[g])));
      assign slot_waw[g] = slot_vld[g] && wr_d && hit(dst_d, slot_dst[g]);
    end
  endgenerate

  // Lowest free slot, one-hot; independent of issue to keep the stall path acyclic
  always_comb begin
    sel      = '0;
    any_free = 1'b0;
    for (int i = 0; i < MC_SLOTS; i++) begin
      if (!slot_vld[i] && !any_free) begin
        sel[i]   = 1'b1;
        any_free = 1'b1;
      end
    end
  end

  assign raw_stall  = |slot_raw;
  assign waw_stall  = |slot_waw;
  assign full_stall = mc_d && !any_free;
  assign stall      = lw_stall || br_stall || raw_stall || waw_stall || full_stall;
  assign stall_f    = stall;
  assign stall_d    = stall;
  assign flush_e    = stall;

  assign issue = mc_d && wr_d && !stall && (dst_d != '0);
  assign load  = sel & {MC_SLOTS{issue}};

  // Fixed latency with one issue per cycle guarantees at most one done bit set
  always_comb begin
    mc_wb_reg = '0;
    for (int i = 0; i < MC_SLOTS; i++)
      if (slot_done[i]) mc_wb_reg = mc_wb_reg | slot_dst[i];
  end

  assign mc_wb_en = |slot_done;
  assign mc_busy  = |slot_vld;

  logic [MC_SLOTS*4-1:0] cnt_unused;
  assign cnt_unused = slot_cnt;
endmodule

// File: tb/tb_mc_hazard_scoreboard.sv
// Self-checking bench for mc_hazard_scoreboard: direct checks on stall/forward outputs
// and a write-back scoreboard of expected (reg, cycle) pairs for multi-cycle results.

module tb_mc_hazard_scoreboard;
  localparam int AW = 5, MC_LAT = 4, MC_SLOTS = 2;

  logic clk = 1'b0, rst = 1'b0;
  logic [AW-1:0] rs_d, rt_d, dst_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;
  logic use_rs_d, use_rt_d, wr_d, mc_d, branch_d;
  logic regwrite_e, memtoreg_e, regwrite_m, memtoreg_m, regwrite_w;
  logic [1:0] forward_ae, forward_be;
  logic forward_ad, forward_bd, stall_f, stall_d, flush_e, mc_wb_en, mc_busy;
  logic [AW-1:0] mc_wb_reg;

  typedef struct { logic [AW-1:0] rd; int cyc; } wb_t;
  wb_t sb_q[$];
  int cyc = 0, nchk = 0, nfail = 0, base;

  mc_hazard_scoreboard #(.AW(AW), .MC_LAT(MC_LAT), .MC_SLOTS(MC_SLOTS)) dut (
    .clk(clk), .rst(rst), .rs_d(rs_d), .rt_d(rt_d), .use_rs_d(use_rs_d), .use_rt_d(use_rt_d),
    .dst_d(dst_d), .wr_d(wr_d), .mc_d(mc_d), .branch_d(branch_d), .rs_e(rs_e), .rt_e(rt_e),
    .writereg_e(writereg_e), .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e),
    .writereg_m(writereg_m), .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m),
    .writereg_w(writereg_w), .regwrite_w(regwrite_w), .forward_ae(forward_ae),
    .forward_be(forward_be), .forward_ad(forward_ad), .forward_bd(forward_bd),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e), .mc_wb_en(mc_wb_en),
    .mc_wb_reg(mc_wb_reg), .mc_busy(mc_busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    chk({tag, "_stall_f"}, {31'd0, stall_f}, {31'd0, exp});
    chk({tag, "_stall_d"}, {31'd0, stall_d}, {31'd0, exp});
    chk({tag, "_flush_e"}, {31'd0, flush_e}, {31'd0, exp});
  endtask

  task automatic clr_in;
    {rs_d, rt_d, dst_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w} = '0;
    {use_rs_d, use_rt_d, wr_d, mc_d, branch_d} = '0;
    {regwrite_e, memtoreg_e, regwrite_m, memtoreg_m, regwrite_w} = '0;
  endtask

  // Inputs change 1ns after the edge; checks happen at +2ns, well before the next edge
  task automatic nxt;
    @(posedge clk); #1;
  endtask

  task automatic mul_in(input logic [AW-1:0] rd);
    clr_in(); mc_d = 1'b1; wr_d = 1'b1; dst_d = rd;
  endtask

  // Write-back monitor: every strobe must match the oldest expected completion
  always @(negedge clk) begin
    if (mc_wb_en) begin
      if (sb_q.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
      else begin
        wb_t e;
        e = sb_q.pop_front();
        chk("wb_reg", {27'd0, mc_wb_reg}, {27'd0, e.rd});
        chk("wb_cyc", cyc, e.cyc);
      end
    end
  end

  initial begin
    clr_in();
    #2;
    chk("rst_busy", {31'd0, mc_busy}, 32'd0);
    chk("rst_wb_en", {31'd0, mc_wb_en}, 32'd0);
    chk("rst_wb_reg", {27'd0, mc_wb_reg}, 32'd0);
    chk_stall("rst_idle", 1'b0);
    nxt(); rst = 1'b1;

    // Forwarding priority and r0
    nxt(); regwrite_m = 1; writereg_m = 5; regwrite_w = 1; writereg_w = 5; rs_e = 5; rt_e = 5;
    #1; chk("fae_m", {30'd0, forward_ae}, 32'd2); chk("fbe_m", {30'd0, forward_be}, 32'd2);
    regwrite_m = 0;
    #1; chk("fae_w", {30'd0, forward_ae}, 32'd1); chk("fbe_w", {30'd0, forward_be}, 32'd1);
    rs_e = 0; regwrite_w = 1; writereg_w = 0;
    #1; chk("fae_r0", {30'd0, forward_ae}, 32'd0);

    // Load-use: one stall cycle, then the load sits in M
    nxt(); clr_in(); memtoreg_e = 1; regwrite_e = 1; writereg_e = 2; rs_d = 2; use_rs_d = 1;
    #1; chk_stall("lw", 1'b1);
    nxt(); memtoreg_e = 0; regwrite_e = 0; writereg_m = 2; regwrite_m = 1; memtoreg_m = 1;
    #1; chk_stall("lw_after", 1'b0);

    // mul r3 then dependent add r3: stalls for MC_LAT cycles
    nxt(); mul_in(3);
    #1; chk_stall("mul3_issue", 1'b0); base = cyc; sb_q.push_back('{3, base + MC_LAT});
    nxt(); clr_in(); rs_d = 3; use_rs_d = 1; wr_d = 1; dst_d = 7;
    #1; chk("mul3_busy", {31'd0, mc_busy}, 32'd1);
    for (int k = 1; k <= MC_LAT; k++) begin
      chk_stall("raw3", 1'b1);
      nxt();
    end
    #1; chk_stall("raw3_release", 1'b0); chk("raw3_at", cyc, base + MC_LAT + 1);

    // Three independent muls with two slots: the third waits for a free slot
    nxt(); mul_in(6);
    #1; chk_stall("mul6", 1'b0); base = cyc; sb_q.push_back('{6, base + MC_LAT});
    nxt(); mul_in(7);
    #1; chk_stall("mul7", 1'b0); sb_q.push_back('{7, base + 1 + MC_LAT});
    nxt(); mul_in(8);
    for (int k = 2; k <= MC_LAT; k++) begin
      #1; chk_stall("full", 1'b1);
      nxt();
    end
    #1; chk_stall("mul8_issue", 1'b0); chk("mul8_at", cyc, base + MC_LAT + 1);
    sb_q.push_back('{8, cyc + MC_LAT});
    nxt(); clr_in();
    repeat (MC_LAT + 1) nxt();
    chk("drain_busy", {31'd0, mc_busy}, 32'd0);

    // Branch hazards
    clr_in(); branch_d = 1; rs_d = 4; rt_d = 9; use_rs_d = 1; use_rt_d = 1;
    regwrite_e = 1; writereg_e = 4;
    #1; chk_stall("br_e", 1'b1);
    nxt(); regwrite_e = 0; regwrite_m = 1; writereg_m = 4;
    #1; chk_stall("br_m_alu", 1'b0);
    chk("fad", {31'd0, forward_ad}, 32'd1); chk("fbd", {31'd0, forward_bd}, 32'd0);

    // mc op writing r0 takes no slot
    nxt(); mul_in(0);
    nxt(); clr_in();
    #1; chk("r0_busy", {31'd0, mc_busy}, 32'd0);

    // Reset mid-flight discards the op
    nxt(); mul_in(10);
    #1; chk_stall("mul10", 1'b0); sb_q.push_back('{10, cyc + MC_LAT});
    nxt(); clr_in();
    nxt();
    #1; chk("mul10_busy", {31'd0, mc_busy}, 32'd1);
    rst = 1'b0;
    #1; chk("arst_busy", {31'd0, mc_busy}, 32'd0); chk("arst_wb", {31'd0, mc_wb_en}, 32'd0);
    void'(sb_q.pop_back());
    memtoreg_e = 1; writereg_e = 2; rs_d = 2; use_rs_d = 1;
    #1; chk_stall("arst_comb", 1'b1);
    nxt(); clr_in(); rst = 1'b1;
    repeat (MC_LAT + 4) nxt();
    chk("post_rst_busy", {31'd0, mc_busy}, 32'd0);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
